// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, FSM states and control-word bit positions for the ALU sequencer.
// ALU_CTRL_DIV_EN selects whether DIV is a legal opcode.
package alu_ctrl_pkg;

  localparam int CTRL_W = 12;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam int C_CLR_A  = 0;
  localparam int C_LD_Q   = 1;
  localparam int C_LD_M   = 2;
  localparam int C_ADD    = 3;
  localparam int C_SUB    = 4;
  localparam int C_SEL_2M = 5;
  localparam int C_LOGIC  = 6;
  localparam int C_ASHR2  = 7;
  localparam int C_SHL    = 8;
  localparam int C_SET_Q0 = 9;
  localparam int C_OUT_Q  = 10;
  localparam int C_OUT_A  = 11;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_EXEC, S_MUL, S_DIV_SH, S_DIV_OP, S_DIV_FIX, S_OUT, S_DONE
  } state_t;

  // Opcodes rejected straight from IDLE; DIV only exists when the divider is built.
  function automatic logic op_is_illegal(input logic [2:0] op);
`ifdef ALU_CTRL_DIV_EN
    return (op == OP_ILL);
`else
    return (op == OP_ILL) || (op == OP_DIV);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_counter.sv
// Loadable down-counter for MUL/DIV iteration tracking; saturates at zero.
module alu_iter_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             is_zero
);

  logic [CNT_W-1:0] r_value;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
    end else if (load) begin
      r_value <= load_val;
    end else if (dec && (r_value != '0)) begin
      r_value <= r_value - 1'b1;
    end
  end

  assign value   = r_value;
  assign is_zero = (r_value == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: logic/add/sub, radix-4 Booth MUL, non-restoring DIV.
// Define ALU_CTRL_DIV_EN to build the DIV states and divide-by-zero detection.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(2*WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              begin_signal,
  input  logic [2:0]        op,
  input  logic [2:0]        booth,
  input  logic              A_msb,
  input  logic              m_zero,
  output logic [CTRL_W-1:0] c,
  output logic              busy,
  output logic              end_signal,
  output logic              err
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(WIDTH/2 - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_op;
  logic              r_err;
  logic [CTRL_W-1:0] w_c;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_load_val;
  logic              w_cnt_dec;
  logic [CNT_W-1:0]  w_cnt_value;
  logic              w_cnt_zero;
  logic              w_accept;
  logic              w_unused;

  assign w_accept = (r_state == S_IDLE) && begin_signal;

  alu_iter_counter #(.CNT_W(CNT_W)) u_iter_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (w_cnt_load),
    .load_val (w_cnt_load_val),
    .dec      (w_cnt_dec),
    .value    (w_cnt_value),
    .is_zero  (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_AND;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op  <= op;
        r_err <= op_is_illegal(op);
      end
`ifdef ALU_CTRL_DIV_EN
      else if ((r_state == S_LOAD) && (r_op == OP_DIV) && m_zero) begin
        r_err <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_c            = '0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (begin_signal) begin
          w_state_next = op_is_illegal(op) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        w_c[C_CLR_A] = 1'b1;
        w_c[C_LD_Q]  = 1'b1;
        w_c[C_LD_M]  = 1'b1;
        case (r_op)
          OP_MUL: begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = MUL_LOAD;
            w_state_next   = S_MUL;
          end
`ifdef ALU_CTRL_DIV_EN
          OP_DIV: begin
            w_cnt_load     = 1'b1;
            w_cnt_load_val = DIV_LOAD;
            w_state_next   = m_zero ? S_DONE : S_DIV_SH;
          end
`endif
          default: w_state_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (r_op)
          OP_ADD:  w_c[C_ADD]   = 1'b1;
          OP_SUB:  w_c[C_SUB]   = 1'b1;
          default: w_c[C_LOGIC] = 1'b1;
        endcase
        w_state_next = S_OUT;
      end
      S_MUL: begin
        // Radix-4 Booth recoding of {Q[1], Q[0], Q[-1]}.
        w_c[C_ASHR2] = 1'b1;
        case (booth)
          3'b001, 3'b010: w_c[C_ADD] = 1'b1;
          3'b011: begin
            w_c[C_ADD]    = 1'b1;
            w_c[C_SEL_2M] = 1'b1;
          end
          3'b100: begin
            w_c[C_SUB]    = 1'b1;
            w_c[C_SEL_2M] = 1'b1;
          end
          3'b101, 3'b110: w_c[C_SUB] = 1'b1;
          default: ;
        endcase
        if (w_cnt_zero) begin
          w_state_next = S_OUT;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
`ifdef ALU_CTRL_DIV_EN
      S_DIV_SH: begin
        w_c[C_SHL]   = 1'b1;
        w_state_next = S_DIV_OP;
      end
      S_DIV_OP: begin
        w_c[C_SET_Q0] = 1'b1;
        if (A_msb) w_c[C_ADD] = 1'b1;
        else       w_c[C_SUB] = 1'b1;
        if (w_cnt_zero) begin
          w_state_next = S_DIV_FIX;
        end else begin
          w_cnt_dec    = 1'b1;
          w_state_next = S_DIV_SH;
        end
      end
      S_DIV_FIX: begin
        // Negative remainder gets M added back once.
        w_c[C_ADD]   = A_msb;
        w_state_next = S_OUT;
      end
`endif
      S_OUT: begin
        w_c[C_OUT_Q] = 1'b1;
        w_c[C_OUT_A] = 1'b1;
        w_state_next = S_DONE;
      end
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign c          = w_c;
  assign busy       = (r_state != S_IDLE);
  assign end_signal = (r_state == S_DONE);
  assign err        = r_err;

`ifdef ALU_CTRL_DIV_EN
  assign w_unused = ^w_cnt_value;
`else
  assign w_unused = ^{w_cnt_value, m_zero, A_msb};
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed self-checking bench for alu_seq_ctrl at WIDTH=8; DIV cases follow ALU_CTRL_DIV_EN.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        begin_signal = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [2:0]  booth = 3'b000;
  logic        A_msb = 1'b0;
  logic        m_zero = 1'b0;
  logic [11:0] c;
  logic        busy;
  logic        end_signal;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq_ctrl #(.WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .begin_signal (begin_signal),
    .op           (op),
    .booth        (booth),
    .A_msb        (A_msb),
    .m_zero       (m_zero),
    .c            (c),
    .busy         (busy),
    .end_signal   (end_signal),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [11:0] e_c, input logic e_busy,
                         input logic e_end, input logic e_err);
    chk({tag, ".c"},   {20'b0, c},          {20'b0, e_c});
    chk({tag, ".busy"}, {31'b0, busy},      {31'b0, e_busy});
    chk({tag, ".end"},  {31'b0, end_signal}, {31'b0, e_end});
    chk({tag, ".err"},  {31'b0, err},        {31'b0, e_err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents begin for one edge; returns in cycle 1 after the sampling edge.
  task automatic start(input logic [2:0] o);
    begin_signal = 1'b1;
    op = o;
    tick();
    begin_signal = 1'b0;
  endtask

  logic [2:0]  ops_tab[4]  = '{3'b000, 3'b001, 3'b010, 3'b100};
  logic [11:0] exec_tab[4] = '{12'h040, 12'h040, 12'h040, 12'h010};
  logic [2:0]  booth_seq[4] = '{3'b011, 3'b100, 3'b001, 3'b000};
  logic [11:0] mul_exp[4]   = '{12'h0A8, 12'h0B0, 12'h088, 12'h080};
  logic [2:0]  booth_x[5]   = '{3'b110, 3'b101, 3'b010, 3'b111, 3'b000};
  logic [11:0] mul_x[5]     = '{12'h090, 12'h090, 12'h088, 12'h080, 12'h080};

  initial begin
    // Reset state
    repeat (2) tick();
    chk_out("rst_hold", 12'h000, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    chk_out("rst_rel", 12'h000, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset checked");

    // ADD, with begin/op=111 presented while busy (must be ignored)
    start(3'b011);
    begin_signal = 1'b1;
    op = 3'b111;
    chk_out("add_c1", 12'h007, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("add_c2", 12'h008, 1'b1, 1'b0, 1'b0);
    tick();
    begin_signal = 1'b0;
    chk_out("add_c3", 12'hC00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("add_c4", 12'h000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("add_idle", 12'h000, 1'b0, 1'b0, 1'b0);
    $display("[TB] ADD op=011 sequence");

    // Logic ops and SUB
    for (int i = 0; i < 4; i++) begin
      start(ops_tab[i]);
      tick();
      chk($sformatf("exec_op%0d.c", ops_tab[i]), {20'b0, c}, {20'b0, exec_tab[i]});
      tick();
      tick();
      chk_out($sformatf("exec_op%0d_done", ops_tab[i]), 12'h000, 1'b1, 1'b1, 1'b0);
      tick();
      $display("[TB] op=%03b EXEC c expected %03h", ops_tab[i], exec_tab[i]);
    end

    // MUL with Booth sequence, extra recodings probed in the last step
    start(3'b101);
    chk_out("mul_c1", 12'h007, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      booth = booth_seq[i];
      #1;
      chk_out($sformatf("mul_step%0d", i), mul_exp[i], 1'b1, 1'b0, 1'b0);
      if (i == 3) begin
        for (int k = 0; k < 5; k++) begin
          booth = booth_x[k];
          #1;
          chk($sformatf("mul_booth%03b.c", booth_x[k]), {20'b0, c}, {20'b0, mul_x[k]});
        end
      end
    end
    tick();
    chk_out("mul_c6", 12'hC00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("mul_c7", 12'h000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("mul_idle", 12'h000, 1'b0, 1'b0, 1'b0);
    $display("[TB] MUL op=101 sequence");

    // Reset during MUL step 2
    start(3'b101);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk_out("mul_abort", 12'h000, 1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("abort_noend%0d", i), {30'b0, busy, end_signal}, 32'd0);
    end
    $display("[TB] MUL aborted by reset");

    // Illegal op, err held until next accepted begin
    start(3'b111);
    chk_out("ill_c1", 12'h000, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("ill_idle", 12'h000, 1'b0, 1'b0, 1'b1);
    tick();
    chk("ill_hold.err", {31'b0, err}, 32'd1);
    start(3'b000);
    chk_out("ill_clear", 12'h007, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    $display("[TB] illegal op=111");

    // begin held through DONE: one idle cycle before the restart
    begin_signal = 1'b1;
    op = 3'b011;
    tick();
    tick();
    tick();
    tick();
    chk_out("hold_done", 12'h000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("hold_idle", 12'h000, 1'b0, 1'b0, 1'b0);
    tick();
    begin_signal = 1'b0;
    chk_out("hold_restart", 12'h007, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    chk("hold_drain.busy", {31'b0, busy}, 32'd0);
    $display("[TB] begin held through DONE");

`ifdef ALU_CTRL_DIV_EN
    // Divide by zero
    m_zero = 1'b1;
    start(3'b110);
    chk_out("dz_c1", 12'h007, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("dz_c2", 12'h000, 1'b1, 1'b1, 1'b1);
    m_zero = 1'b0;
    tick();
    chk_out("dz_idle", 12'h000, 1'b0, 1'b0, 1'b1);
    $display("[TB] DIV by zero");

    // Full DIV with A_msb toggling
    start(3'b110);
    chk_out("div_c1", 12'h007, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out($sformatf("div_sh%0d", i), 12'h100, 1'b1, 1'b0, 1'b0);
      tick();
      A_msb = (i % 2 == 1);
      #1;
      chk_out($sformatf("div_op%0d", i), A_msb ? 12'h208 : 12'h210, 1'b1, 1'b0, 1'b0);
    end
    tick();
    A_msb = 1'b1;
    #1;
    chk_out("div_fix1", 12'h008, 1'b1, 1'b0, 1'b0);
    A_msb = 1'b0;
    #1;
    chk_out("div_fix0", 12'h000, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("div_c19", 12'hC00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("div_c20", 12'h000, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("div_idle", 12'h000, 1'b0, 1'b0, 1'b0);
    $display("[TB] DIV op=110 sequence");
`else
    // DIV not built: op 110 is illegal with 1-cycle latency
    m_zero = 1'b1;
    start(3'b110);
    chk_out("divoff_c1", 12'h000, 1'b1, 1'b1, 1'b1);
    m_zero = 1'b0;
    tick();
    chk_out("divoff_idle", 12'h000, 1'b0, 1'b0, 1'b1);
    $display("[TB] op=110 with divider absent");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
